// File: rtl/axi4_lite_master_arb.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_arb
//
// Round-robin arbiter and sequencer that lets two requesters share a single
// AXI4-lite master port. Each requester presents single-beat read or write
// commands on a valid/ready port and receives a one-cycle response pulse.
// Only one AXI transaction is ever in flight.
//
// Ports
//   ACLK, ARESET       clock, asynchronous active-high reset
//   req_valid/ready    per-requester command handshake (bit i = requester i)
//   req_write          1 = write, 0 = read
//   req_addr/wdata/    per-requester command payload, requester i packed at
//   req_wstrb          [i*W +: W]
//   rsp_valid          one-cycle response pulse to the owning requester
//   rsp_rdata/resp     shared response payload, valid with rsp_valid
//   AW*/W*/B*          AXI4-lite write address / data / response channels
//   AR*/R*             AXI4-lite read address / data channels
// ---------------------------------------------------------------------------
module axi4_lite_master_arb #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [2:0]  PROT_DEFAULT = 3'b000
) (
    input  logic                        ACLK,
    input  logic                        ARESET,

    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_write,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,

    output logic [ADDR_WIDTH-1:0]       AWADDR,
    output logic [2:0]                  AWPROT,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [DATA_WIDTH-1:0]       WDATA,
    output logic [DATA_WIDTH/8-1:0]     WSTRB,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY,

    output logic [ADDR_WIDTH-1:0]       ARADDR,
    output logic [2:0]                  ARPROT,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [DATA_WIDTH-1:0]       RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RVALID,
    output logic                        RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for a command
        S_WR,     // AW and/or W still pending
        S_WB,     // waiting for B
        S_RA,     // AR pending
        S_RD      // waiting for R
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic                    grant_idx;
    logic [1:0]              grant_oh;
    logic                    aw_done;
    logic                    w_done;

    // On a tie the requester that did not win last time is served; a lone
    // requester is served regardless of history.
    always_comb begin
        grant_idx = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        grant_oh  = 2'b00;
        if (state_q == S_IDLE && req_valid != 2'b00) begin
            grant_oh = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // The accept strobe is combinational so the command is taken in the same
    // cycle it is granted; it is forced low while reset is held.
    assign req_ready = ARESET ? 2'b00 : grant_oh;

    // A channel counts as done if it already completed or completes now.
    assign aw_done = !awvalid_q || AWREADY;
    assign w_done  = !wvalid_q  || WREADY;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    addr_d  = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
                    wdata_d = grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_wdata[DATA_WIDTH-1:0];
                    wstrb_d = grant_idx ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                        : req_wstrb[STRB_WIDTH-1:0];
                    if (req_write[grant_idx]) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RA;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_WR: begin
                // AW and W retire independently, in either order.
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = S_WB;
                    bready_d = 1'b1;
                end
            end

            S_WB: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_IDLE;
                end
            end

            S_RA: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end

            S_RD: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = RRESP;
                    rsp_rdata_d = RDATA;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    assign AWADDR    = addr_q;
    assign AWPROT    = PROT_DEFAULT;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARPROT    = PROT_DEFAULT;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master_arb.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_arb
//
// Directed bench for axi4_lite_master_arb. A negedge process acts as the AXI
// slave (configurable wait states and responses) and holds a transaction-level
// model of the arbiter: who must be granted, which channel VALID/READY must be
// up for the outstanding command, and which response pulse is due. The main
// process drives requester commands and pins the model with literal values.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b0;

    logic            v0, v1, w0, w1;
    logic [AW-1:0]   a0, a1;
    logic [DW-1:0]   d0, d1;
    logic [SW-1:0]   s0, s1;

    logic [1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_wstrb;
    logic [DW-1:0]   rsp_rdata;

    logic [AW-1:0]   AWADDR, ARADDR;
    logic [2:0]      AWPROT, ARPROT;
    logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic            ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]   WDATA, RDATA;
    logic [SW-1:0]   WSTRB;
    logic [1:0]      BRESP, RRESP;

    assign req_valid = {v1, v0};
    assign req_write = {w1, w0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};
    assign req_wstrb = {s1, s0};

    axi4_lite_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_DEFAULT(3'b000)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s: got no event within the cycle budget, required one", nm);
    endtask

    // Slave behaviour, set by the main process away from the negedge.
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
    int          cfg_ar_wait = 0, cfg_r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    typedef struct {
        logic        owner;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } txn_t;

    // -------------------- slave + reference model --------------------
    txn_t        t, nxt;
    bit          have, aw_done, w_done, ar_done, model_last;
    bit          hs_aw, hs_w, hs_ar, hs_b, hs_r, hs_grant, pulse_now;
    bit          p_owner;
    logic [1:0]  p_resp, exp_ready;
    logic [31:0] p_rdata;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          widx;

    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        have = 0; model_last = 1;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0; hs_grant = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                have = 0; model_last = 1;
                hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0; hs_grant = 0;
                chk("reset_ctl", {req_ready, rsp_valid, rsp_resp, AWVALID, WVALID,
                                  ARVALID, BREADY, RREADY}, 64'h0);
                chk("reset_addr", {AWADDR, ARADDR}, 64'h0);
                chk("reset_wdata", {WSTRB, WDATA}, 64'h0);
                chk("reset_rdata", rsp_rdata, 64'h0);
                continue;
            end

            // Apply the handshakes that completed at the edge just passed.
            pulse_now = 0;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            if (hs_ar) ar_done = 1;
            if (hs_b) begin
                BVALID = 0; pulse_now = 1; p_owner = t.owner;
                p_resp = BRESP; p_rdata = 32'h0; have = 0;
            end
            if (hs_r) begin
                RVALID = 0; pulse_now = 1; p_owner = t.owner;
                p_resp = RRESP; p_rdata = RDATA; have = 0;
            end
            if (hs_grant) begin
                t = nxt; have = 1;
                aw_done = 0; w_done = 0; ar_done = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end

            // Slave drives for the coming edge.
            AWREADY = AWVALID && (aw_cnt >= cfg_aw_wait);
            if (AWVALID) aw_cnt++;
            WREADY = WVALID && (w_cnt >= cfg_w_wait);
            if (WVALID) w_cnt++;
            ARREADY = ARVALID && (ar_cnt >= cfg_ar_wait);
            if (ARVALID) ar_cnt++;
            if (have && t.w && aw_done && w_done && !BVALID) begin
                if (b_cnt >= cfg_b_wait) begin BVALID = 1; BRESP = cfg_bresp; end
                else b_cnt++;
            end
            if (have && !t.w && ar_done && !RVALID) begin
                if (r_cnt >= cfg_r_wait) begin
                    RVALID = 1; RDATA = cfg_rdata; RRESP = cfg_rresp;
                end else r_cnt++;
            end

            // Expected arbiter outputs.
            exp_ready = 2'b00;
            if (!have && req_valid != 2'b00)
                exp_ready = (req_valid == 2'b11) ? (model_last ? 2'b01 : 2'b10) : req_valid;
            chk("req_ready", req_ready, exp_ready);
            hs_grant = (exp_ready != 2'b00);
            if (hs_grant) begin
                widx      = exp_ready[1];
                nxt.owner = widx;
                nxt.w     = req_write[widx];
                nxt.a     = widx ? a1 : a0;
                nxt.d     = widx ? d1 : d0;
                nxt.s     = widx ? s1 : s0;
                model_last = widx;
            end

            chk("chan_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY},
                {have && t.w && !aw_done, have && t.w && !w_done,
                 have && !t.w && !ar_done, have && t.w && aw_done && w_done,
                 have && !t.w && ar_done});
            if (AWVALID) chk("aw_payload", {AWPROT, AWADDR}, {3'b000, t.a});
            if (WVALID)  chk("w_payload", {WSTRB, WDATA}, {t.s, t.d});
            if (ARVALID) chk("ar_payload", {ARPROT, ARADDR}, {3'b000, t.a});

            chk("rsp_valid", rsp_valid, pulse_now ? (p_owner ? 2'b10 : 2'b01) : 2'b00);
            if (pulse_now) begin
                chk("rsp_resp", rsp_resp, p_resp);
                chk("rsp_rdata", rsp_rdata, p_rdata);
            end

            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            hs_ar = ARVALID && ARREADY;
            hs_b  = BVALID && BREADY;
            hs_r  = RVALID && RREADY;
        end
    end

    // -------------------- requester side --------------------
    task automatic cfg_set(input int aww, input int ww, input int bw, input int arw,
                           input int rw, input logic [1:0] br, input logic [1:0] rr,
                           input logic [31:0] rd);
        @(posedge ACLK); #1;
        cfg_aw_wait = aww; cfg_w_wait = ww; cfg_b_wait = bw;
        cfg_ar_wait = arw; cfg_r_wait = rw;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
    endtask

    task automatic issue(input bit i, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit ok;
        @(posedge ACLK); #1;
        if (!i) begin w0 = w; a0 = a; d0 = d; s0 = s; v0 = 1; end
        else    begin w1 = w; a1 = a; d1 = d; s1 = s; v1 = 1; end
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (req_ready[i]) begin ok = 1; break; end
        end
        if (!ok) tmo("grant_wait");
        @(posedge ACLK); #1;
        if (!i) v0 = 0; else v1 = 0;
    endtask

    task automatic wait_rsp(input bit i, output logic [1:0] r, output logic [31:0] d);
        bit ok;
        ok = 0; r = 2'bxx; d = 'x;
        for (int k = 0; k < 60; k++) begin
            @(negedge ACLK);
            if (rsp_valid[i]) begin ok = 1; r = rsp_resp; d = rsp_rdata; break; end
        end
        if (!ok) tmo("rsp_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    logic [1:0]  r;
    logic [31:0] rd;
    int          cnt, k0, k1;
    int          g[$];
    logic [7:0]  exp_pat;
    bit          got0, got1, ok;

    initial begin
        v0 = 0; v1 = 0; w0 = 0; w1 = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;
        #1 ARESET = 1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;

        // Single write, zero-wait slave.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge ACLK);
        chk("t1_awaddr", AWADDR, 32'h10);
        chk("t1_wdata", WDATA, 32'hDEADBEEF);
        chk("t1_valids", {AWVALID, WVALID}, 2'b11);
        wait_rsp(0, r, rd);
        chk("t1_resp", r, 2'b00);
        chk("t1_rdata", rd, 32'h0);

        // Split write: W accepted two cycles before AW.
        cfg_set(2, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        issue(0, 1, 32'h30, 32'hA5A50F0F, 4'h3);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (!AWVALID) break;
            if (!WVALID) cnt++;
        end
        chk("t2_aw_only_cycles", cnt, 2);
        wait_rsp(0, r, rd);
        chk("t2_resp", r, 2'b00);

        // Read with AR and R wait states, from requester 1.
        cfg_set(0, 0, 0, 2, 2, 2'b00, 2'b00, 32'h12345678);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (!ARVALID) break;
            if (ARADDR == 32'h20) cnt++;
        end
        chk("t3_arvalid_cycles", cnt, 3);
        wait_rsp(1, r, rd);
        chk("t3_resp", r, 2'b00);
        chk("t3_rdata", rd, 32'h12345678);

        // Contention: both requesters hold valid for four writes each.
        cfg_set(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        @(posedge ACLK); #1;
        k0 = 0; k1 = 0;
        w0 = 1; a0 = 32'h100; d0 = 32'hA0000000; s0 = 4'hF; v0 = 1;
        w1 = 1; a1 = 32'h200; d1 = 32'hB0000000; s1 = 4'hC; v1 = 1;
        for (int c = 0; c < 200 && g.size() < 8; c++) begin
            @(negedge ACLK);
            got0 = req_ready[0]; got1 = req_ready[1];
            if (got0) g.push_back(0);
            if (got1) g.push_back(1);
            if (got0 || got1) begin
                @(posedge ACLK); #1;
                if (got0) begin
                    k0++;
                    if (k0 < 4) begin a0 = 32'h100 + 32'(k0 * 4); d0 = 32'hA0000000 + 32'(k0); end
                    else v0 = 0;
                end
                if (got1) begin
                    k1++;
                    if (k1 < 4) begin a1 = 32'h200 + 32'(k1 * 4); d1 = 32'hB0000000 + 32'(k1); end
                    else v1 = 0;
                end
            end
        end
        v0 = 0; v1 = 0;
        chk("t4_grant_count", g.size(), 8);
        exp_pat = 8'b10101010;
        for (int k = 0; k < g.size() && k < 8; k++)
            chk($sformatf("t4_grant_%0d", k), g[k], exp_pat[k]);
        wait_rsp(1, r, rd);
        chk("t4_last_resp", r, 2'b00);

        // Error response pass-through, then a normal read.
        cfg_set(0, 0, 0, 0, 1, 2'b00, 2'b10, 32'hCAFE0001);
        issue(1, 0, 32'h40, 32'h0, 4'h0);
        wait_rsp(1, r, rd);
        chk("t5_err_resp", r, 2'b10);
        chk("t5_err_rdata", rd, 32'hCAFE0001);
        cfg_set(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BADF00D);
        issue(0, 0, 32'h44, 32'h0, 4'h0);
        wait_rsp(0, r, rd);
        chk("t5_ok_resp", r, 2'b00);
        chk("t5_ok_rdata", rd, 32'h0BADF00D);

        // Reset while a write is stalled on AW/W.
        cfg_set(20, 20, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        issue(0, 1, 32'h50, 32'h55AA55AA, 4'hF);
        @(negedge ACLK);
        chk("t6_valids_before", {AWVALID, WVALID}, 2'b11);
        #2 ARESET = 1;
        #1;
        chk("t6_valids_async", {AWVALID, WVALID}, 2'b00);
        chk("t6_no_rsp", rsp_valid, 2'b00);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        cfg_set(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        w0 = 1; a0 = 32'h60; d0 = 32'h11112222; s0 = 4'hF; v0 = 1;
        w1 = 1; a1 = 32'h64; d1 = 32'h33334444; s1 = 4'hF; v1 = 1;
        @(negedge ACLK);
        chk("t6_first_grant", req_ready, 2'b01);
        @(posedge ACLK); #1 v0 = 0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (req_ready[1]) begin ok = 1; break; end
        end
        if (!ok) tmo("t6_second_grant");
        @(posedge ACLK); #1 v1 = 0;
        wait_rsp(1, r, rd);
        chk("t6_resp", r, 2'b00);

        repeat (3) @(posedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
